// File: rtl/scroll_pacer.sv
// scroll_pacer
//
// Purpose:
//   Turns the per-frame sync from the VGA timing generator into bursts of
//   single-cycle move strobes for the falling-object movers. Every FRAME_DIV
//   frames a burst of `speed` consecutive move cycles is issued, so each
//   object advances `speed` pixels per FRAME_DIV frames.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   frame_sync  in   frame sync, synchronous to clk; rising edge = frame start
//   enable      in   game running (level)
//   pause       in   freeze pacing (level)
//   speed_up    in   one-cycle pulse, raise speed by one (saturating)
//   speed_down  in   one-cycle pulse, lower speed by one (saturating at 1)
//   move        out  move strobe, high for `speed` cycles per burst
//   speed       out  current speed level
//   paused      out  high while pacing is frozen
//   move_total  out  number of move cycles since the game was started
module scroll_pacer #(
  parameter int FRAME_DIV  = 2,
  parameter int MAX_SPEED  = 8,
  parameter int INIT_SPEED = 1,
  parameter int SPEED_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_sync,
  input  logic               enable,
  input  logic               pause,
  input  logic               speed_up,
  input  logic               speed_down,
  output logic               move,
  output logic [SPEED_W-1:0] speed,
  output logic               paused,
  output logic [15:0]        move_total
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  localparam logic [3:0]         DIV_LAST   = 4'(FRAME_DIV - 1);
  localparam logic [SPEED_W-1:0] SPEED_ONE  = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(INIT_SPEED);

  logic [1:0]         state;
  logic               prev_sync;
  logic [3:0]         div_cnt;
  logic [SPEED_W-1:0] burst_cnt;
  logic               pending;

  logic frame_tick;
  logic div_last;
  logic div_done;

  // Rising edge of frame_sync. prev_sync resets high so a sync line that is
  // already high when reset releases does not count as a new frame.
  always_comb begin
    frame_tick = frame_sync & ~prev_sync;
    div_last   = (div_cnt == DIV_LAST);
    div_done   = frame_tick & div_last;
  end

  // Outputs are pure state decodes so the movers see glitch-free strobes.
  assign move   = (state == BURST);
  assign paused = (state == PAUSE);

  // Speed level is independent of the pacing state: it survives IDLE and
  // PAUSE and only reset restores the initial level. Simultaneous up and
  // down requests cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed <= SPEED_INIT;
    end else if (speed_up && !speed_down && (speed < SPEED_MAX)) begin
      speed <= speed + SPEED_ONE;
    end else if (speed_down && !speed_up && (speed > SPEED_ONE)) begin
      speed <= speed - SPEED_ONE;
    end
  end

  // Pacing state machine. Enable has top priority, then pause, then frame
  // ticks. The frame divider keeps counting during a burst; a divider wrap
  // inside a burst is remembered in `pending` (or taken directly if it lands
  // on the last burst cycle) so the next burst follows with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_sync  <= 1'b1;
      div_cnt    <= '0;
      burst_cnt  <= '0;
      pending    <= 1'b0;
      move_total <= '0;
    end else begin
      prev_sync <= frame_sync;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          pending <= 1'b0;
          if (enable) begin
            state      <= WAIT;
            move_total <= '0;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (pause) begin
            state <= PAUSE;
          end else if (frame_tick) begin
            if (div_last) begin
              div_cnt   <= '0;
              burst_cnt <= speed;
              state     <= BURST;
            end else begin
              div_cnt <= div_cnt + 4'd1;
            end
          end
        end

        BURST: begin
          move_total <= move_total + 16'd1;
          burst_cnt  <= burst_cnt - SPEED_ONE;
          if (!enable) begin
            state   <= IDLE;
            div_cnt <= '0;
            pending <= 1'b0;
          end else begin
            if (frame_tick) begin
              div_cnt <= div_last ? 4'd0 : div_cnt + 4'd1;
            end
            if (burst_cnt == SPEED_ONE) begin
              pending <= 1'b0;
              if (pending || div_done) begin
                burst_cnt <= speed;
              end else if (pause) begin
                state <= PAUSE;
              end else begin
                state <= WAIT;
              end
            end else if (div_done) begin
              pending <= 1'b1;
            end
          end
        end

        PAUSE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (!pause) begin
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_pacer.sv
// tb_scroll_pacer
//
// Purpose:
//   Self-checking bench for scroll_pacer. A short table of per-cycle vectors,
//   hand-written multi-cycle sequences for cadence, saturation, pause,
//   mid-burst control, reset and back-to-back bursts, and a randomized run
//   compared against a frame/burst-accounting reference model.
//
// Ports: none (top-level bench).
module tb_scroll_pacer;

  localparam int FD   = 2;
  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_sync = 1'b0;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        speed_up = 1'b0;
  logic        speed_down = 1'b0;

  logic        move;
  logic [3:0]  speed;
  logic        paused;
  logic [15:0] move_total;

  logic        move1;
  logic [3:0]  speed1;
  logic        paused1;
  logic [15:0] total1;

  int n_checks = 0;
  int n_bad = 0;

  scroll_pacer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .enable     (enable),
    .pause      (pause),
    .speed_up   (speed_up),
    .speed_down (speed_down),
    .move       (move),
    .speed      (speed),
    .paused     (paused),
    .move_total (move_total)
  );

  // Second instance with a one-frame divider, used for back-to-back bursts.
  scroll_pacer #(.FRAME_DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .enable     (enable),
    .pause      (pause),
    .speed_up   (speed_up),
    .speed_down (speed_down),
    .move       (move1),
    .speed      (speed1),
    .paused     (paused1),
    .move_total (total1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, pa, fs, up, dn;
    logic        exp_move, exp_paused;
    logic [3:0]  exp_speed;
    logic [15:0] exp_total;
  } vec_t;

  vec_t vecs [17];

  // Reference model state: a game session flag, a frozen flag, the number of
  // move cycles still owed, a queued-burst flag and a frame counter.
  bit m_active, m_frozen, m_extra, m_prev;
  int m_owed, m_frames, m_speed, m_total;

  function automatic vec_t mk(input bit [4:0] in, input bit [1:0] mp,
                              input int spd, input int tot);
    vec_t v;
    v.en = in[4]; v.pa = in[3]; v.fs = in[2]; v.up = in[1]; v.dn = in[0];
    v.exp_move = mp[1]; v.exp_paused = mp[0];
    v.exp_speed = 4'(spd);
    v.exp_total = 16'(tot);
    return v;
  endfunction

  task automatic applyStimulus(input bit en, input bit pa, input bit fs,
                               input bit up, input bit dn);
    enable = en; pause = pa; frame_sync = fs; speed_up = up; speed_down = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input bit e_move, input bit e_paused,
                             input int e_speed, input int e_total);
    checkValue({name, ".move"}, int'(move), int'(e_move));
    checkValue({name, ".paused"}, int'(paused), int'(e_paused));
    checkValue({name, ".speed"}, int'(speed), e_speed);
    checkValue({name, ".total"}, int'(move_total), e_total);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Enable, then deliver two frame edges; with the default divider the
  // second one starts a burst.
  task automatic twoTicks();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
  endtask

  task automatic modelReset();
    m_active = 0; m_frozen = 0; m_extra = 0; m_prev = 1;
    m_owed = 0; m_frames = 0; m_speed = 1; m_total = 0;
  endtask

  task automatic modelStep(input bit en, input bit pa, input bit fs,
                           input bit up, input bit dn);
    bit tick;
    tick = fs && !m_prev;
    m_prev = fs;
    if (!m_active) begin
      m_frames = 0; m_extra = 0;
      if (en) begin
        m_active = 1; m_total = 0;
      end
    end else begin
      if (m_owed > 0) m_total = (m_total + 1) % 65536;
      if (!en) begin
        m_active = 0; m_frozen = 0; m_owed = 0; m_frames = 0; m_extra = 0;
      end else if (m_owed > 0) begin
        m_owed--;
        if (tick) begin
          m_frames++;
          if (m_frames == FD) begin
            m_frames = 0; m_extra = 1;
          end
        end
        if (m_owed == 0) begin
          if (m_extra) begin
            m_extra = 0; m_owed = m_speed;
          end else if (pa) begin
            m_frozen = 1;
          end
        end
      end else if (m_frozen) begin
        if (!pa) m_frozen = 0;
      end else if (pa) begin
        m_frozen = 1;
      end else if (tick) begin
        m_frames++;
        if (m_frames == FD) begin
          m_frames = 0; m_owed = m_speed;
        end
      end
    end
    if (up && !dn && m_speed < MAXS) m_speed++;
    if (dn && !up && m_speed > 1) m_speed--;
  endtask

  initial begin
    int moves, first_at, second_at, bad_cycles, run;
    bit ended, en_r, pa_r, fs_r, up_r, dn_r;

    vecs[0]  = mk(5'b10000, 2'b00, 1, 0);
    vecs[1]  = mk(5'b10100, 2'b00, 1, 0);
    vecs[2]  = mk(5'b10000, 2'b00, 1, 0);
    vecs[3]  = mk(5'b10100, 2'b10, 1, 0);
    vecs[4]  = mk(5'b10000, 2'b00, 1, 1);
    vecs[5]  = mk(5'b10010, 2'b00, 2, 1);
    vecs[6]  = mk(5'b10100, 2'b00, 2, 1);
    vecs[7]  = mk(5'b11000, 2'b01, 2, 1);
    vecs[8]  = mk(5'b11100, 2'b01, 2, 1);
    vecs[9]  = mk(5'b10000, 2'b00, 2, 1);
    vecs[10] = mk(5'b10100, 2'b10, 2, 1);
    vecs[11] = mk(5'b10000, 2'b10, 2, 2);
    vecs[12] = mk(5'b10000, 2'b00, 2, 3);
    vecs[13] = mk(5'b10011, 2'b00, 2, 3);
    vecs[14] = mk(5'b10001, 2'b00, 1, 3);
    vecs[15] = mk(5'b10001, 2'b00, 1, 3);
    vecs[16] = mk(5'b00000, 2'b00, 1, 3);

    $display("[TB] reset and vector table");
    doReset();
    checkOutput("reset", 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].pa, vecs[i].fs, vecs[i].up, vecs[i].dn);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_move, vecs[i].exp_paused,
                  int'(vecs[i].exp_speed), int'(vecs[i].exp_total));
    end

    // Frame edges every 100 cycles starting at cycle 10; bursts after the
    // 2nd and 4th edges only.
    $display("[TB] basic cadence");
    doReset();
    moves = 0; first_at = -1; second_at = -1;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1, 0, (c >= 10) && (((c - 10) % 100) < 50), 0, 0);
      if (move) begin
        moves++;
        if (first_at < 0) first_at = c + 1;
        else if (second_at < 0) second_at = c + 1;
      end
    end
    checkValue("cadence.moves", moves, 2);
    checkValue("cadence.first", first_at, 111);
    checkValue("cadence.second", second_at, 311);
    checkValue("cadence.total", int'(move_total), 2);

    $display("[TB] speed saturation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkValue("sat.max", int'(speed), 8);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkValue("sat.min", int'(speed), 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkValue("sat.both", int'(speed), 1);

    // One edge, then a long pause with edges arriving; the held divider
    // means the first edge after release starts a burst.
    $display("[TB] pause holds divider");
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    bad_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, (i % 20) < 10, 0, 0);
      if (move || !paused) bad_cycles++;
    end
    checkValue("pause.held_cycles_wrong", bad_cycles, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("pause.released", int'(paused), 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkValue("pause.first_tick_fires", int'(move), 1);

    $display("[TB] disable mid-burst");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
    checkValue("mid.speed", int'(speed), 8);
    twoTicks();
    checkValue("mid.burst_start", int'(move), 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("mid.move_after_disable", int'(move), 0);
    checkValue("mid.total", int'(move_total), 3);

    $display("[TB] pause mid-burst");
    twoTicks();
    checkValue("pmid.burst_start", int'(move), 1);
    moves = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (move) moves++;
      if (paused) break;
    end
    checkValue("pmid.moves", moves, 8);
    checkValue("pmid.paused", int'(paused), 1);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 0, 0, 0, 0);
    twoTicks();
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("rmid.in_burst", int'(move), 1);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    rst = 1'b0;
    checkValue("rmid.move", int'(move), 0);
    checkValue("rmid.speed", int'(speed), 1);
    checkValue("rmid.total", int'(move_total), 0);

    // Single-frame divider: a second edge inside a burst chains a second
    // burst with no gap.
    $display("[TB] chained bursts");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
    checkValue("chain.speed", int'(speed1), 8);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    run = move1 ? 1 : 0;
    ended = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1, 0, (i == 4), 0, 0);
      if (move1 && !ended) run++;
      else ended = 1;
    end
    checkValue("chain.run", run, 16);
    checkValue("chain.total", int'(total1), 16);
    checkValue("chain.paused", int'(paused1), 0);

    $display("[TB] randomized run");
    doReset();
    modelReset();
    en_r = 0; pa_r = 0; fs_r = 0;
    for (int c = 0; c < 2000; c++) begin
      if (en_r) en_r = ($urandom_range(0, 299) != 0);
      else      en_r = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) pa_r = !pa_r;
      if ($urandom_range(0, 5) == 0) fs_r = !fs_r;
      up_r = ($urandom_range(0, 39) == 0);
      dn_r = ($urandom_range(0, 39) == 0);
      modelStep(en_r, pa_r, fs_r, up_r, dn_r);
      applyStimulus(en_r, pa_r, fs_r, up_r, dn_r);
      checkOutput($sformatf("rand%0d", c), m_owed > 0, m_frozen, m_speed, m_total);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
